// File: rtl/top_pkg.sv
// Shared RV32I decode constants, access-size encoding and ALU helper.
// Imported by the interface, datapath, register file and top.
package top_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    // funct3[1:0] of loads/stores: 00 byte, 01 half, 10 word
    function automatic size_e size_f(input logic [1:0] f3lo);
        size_e s;
        case (f3lo)
            2'b00:   s = SZ_BYTE;
            2'b01:   s = SZ_HALF;
            default: s = SZ_WORD;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] alu_f(
        input logic [2:0]  f3,
        input logic        alt,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        logic [4:0]  sh;
        r  = '0;
        sh = b[4:0];
        case (f3)
            F3_ADD:  r = alt ? (a - b) : (a + b);
            F3_SLL:  r = a << sh;
            F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: r = {31'b0, a < b};
            F3_XOR:  r = a ^ b;
            F3_SR: begin
                // separate arms keep the arithmetic shift signed
                if (alt) r = $signed(a) >>> sh;
                else     r = a >> sh;
            end
            F3_OR:   r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/top_if.sv
// Fetch/data bus bundle between the core datapath and the pin wrapper.
// master: datapath side; slave: pin side (drives fetched word and load data).
interface top_if;
    logic [31:0] iad;
    logic [31:0] idt;
    logic [31:0] dad;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mreq;
    logic        write;
    logic [1:0]  size;

    modport master (
        output iad, dad, wdata, mreq, write, size,
        input  idt, rdata
    );

    modport slave (
        input  iad, dad, wdata, mreq, write, size,
        output idt, rdata
    );
endinterface

// File: rtl/top_datapath.sv
// Single-cycle RV32I datapath: PC, decode, ALU, branch, load/store.
// Ports: i_clk, i_rst_n (async active-low), bus (top_if.master).
module top_datapath
    import top_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    top_if.master bus
);
    logic [31:0] r_pc;
    logic [31:0] w_ins;
    logic [31:0] w_pc4;
    logic [6:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1v;
    logic [31:0] w_rs2v;
    logic [31:0] w_alu;
    logic [31:0] w_ld;
    logic [31:0] w_wd;
    logic [31:0] w_npc;
    logic [31:0] w_dad;
    logic        w_alt;
    logic        w_take;
    logic        w_wen;
    logic        w_mreq;
    logic        w_write;
    size_e       w_size;

    assign w_ins = bus.idt;
    assign w_op  = w_ins[6:0];
    assign w_rd  = w_ins[11:7];
    assign w_f3  = w_ins[14:12];
    assign w_rs1 = w_ins[19:15];
    assign w_rs2 = w_ins[24:20];
    assign w_pc4 = r_pc + 32'd4;

    assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
    assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25],
                      w_ins[11:7]};
    assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7],
                      w_ins[30:25], w_ins[11:8], 1'b0};
    assign w_imm_u = {w_ins[31:12], 12'b0};
    assign w_imm_j = {{11{w_ins[31]}}, w_ins[31],
                      w_ins[19:12], w_ins[20],
                      w_ins[30:21], 1'b0};

    top_rf rf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_wen),
        .i_wa    (w_rd),
        .i_wd    (w_wd),
        .i_ra1   (w_rs1),
        .i_ra2   (w_rs2),
        .o_rd1   (w_rs1v),
        .o_rd2   (w_rs2v)
    );

    // bit30 selects SUB/SRA; on OP-IMM only SRAI uses it
    assign w_alt = w_ins[30] &
                   ((w_op == OP_OP) | (w_f3 == F3_SR));
    assign w_alu = alu_f(w_f3, w_alt, w_rs1v,
                         (w_op == OP_OP) ? w_rs2v : w_imm_i);

    assign w_dad = w_rs1v +
                   ((w_op == OP_STORE) ? w_imm_s : w_imm_i);

    always_comb begin
        w_take = 1'b0;
        case (w_f3)
            F3_BEQ:  w_take = (w_rs1v == w_rs2v);
            F3_BNE:  w_take = (w_rs1v != w_rs2v);
            F3_BLT:  w_take = ($signed(w_rs1v) < $signed(w_rs2v));
            F3_BGE:  w_take = ($signed(w_rs1v) >= $signed(w_rs2v));
            F3_BLTU: w_take = (w_rs1v < w_rs2v);
            F3_BGEU: w_take = (w_rs1v >= w_rs2v);
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_ld = bus.rdata;
        case (w_f3)
            F3_LB:   w_ld = {{24{bus.rdata[7]}}, bus.rdata[7:0]};
            F3_LH:   w_ld = {{16{bus.rdata[15]}}, bus.rdata[15:0]};
            F3_LBU:  w_ld = {24'b0, bus.rdata[7:0]};
            F3_LHU:  w_ld = {16'b0, bus.rdata[15:0]};
            default: w_ld = bus.rdata;
        endcase
    end

    always_comb begin
        w_npc   = w_pc4;
        w_wen   = 1'b0;
        w_wd    = w_alu;
        w_mreq  = 1'b0;
        w_write = 1'b0;
        w_size  = SZ_WORD;
        unique case (1'b1)
            (w_op == OP_LUI): begin
                w_wen = 1'b1;
                w_wd  = w_imm_u;
            end
            (w_op == OP_AUIPC): begin
                w_wen = 1'b1;
                w_wd  = r_pc + w_imm_u;
            end
            (w_op == OP_JAL): begin
                w_npc = r_pc + w_imm_j;
                w_wen = 1'b1;
                w_wd  = w_pc4;
            end
            (w_op == OP_JALR): begin
                w_npc = (w_rs1v + w_imm_i) & ~32'd1;
                w_wen = 1'b1;
                w_wd  = w_pc4;
            end
            (w_op == OP_BRANCH): begin
                if (w_take) w_npc = r_pc + w_imm_b;
            end
            (w_op == OP_LOAD): begin
                w_mreq = 1'b1;
                w_size = size_f(w_f3[1:0]);
                w_wen  = 1'b1;
                w_wd   = w_ld;
            end
            (w_op == OP_STORE): begin
                w_mreq  = 1'b1;
                w_write = 1'b1;
                w_size  = size_f(w_f3[1:0]);
            end
            (w_op == OP_IMM || w_op == OP_OP): begin
                w_wen = 1'b1;
            end
            default: begin
                w_npc = w_pc4;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pc <= '0;
        else          r_pc <= w_npc;
    end

    // no bus activity while reset is held
    assign bus.iad   = r_pc;
    assign bus.dad   = w_dad;
    assign bus.wdata = w_rs2v;
    assign bus.mreq  = w_mreq & i_rst_n;
    assign bus.write = w_write & i_rst_n;
    assign bus.size  = i_rst_n ? w_size : SZ_WORD;

endmodule

// File: rtl/top_rf.sv
// 32x32 register file, 2 read / 1 write ports, x0 hardwired to zero.
// Ports: i_we/i_wa/i_wd write, i_ra1/i_ra2 -> o_rd1/o_rd2 async read.
module top_ram_2r_w_s_dff (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    // register i lives at bits [32i+31:32i]
    logic [1023:0] mem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  mem <= '0;
        else if (i_we) mem[{i_wa, 5'b0} +: 32] <= i_wd;
    end

    assign o_rd1 = mem[{i_ra1, 5'b0} +: 32];
    assign o_rd2 = mem[{i_ra2, 5'b0} +: 32];
endmodule

module top_rf (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic        w_we;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    assign w_we = i_we & (i_wa != 5'd0);

    top_ram_2r_w_s_dff u_DW_ram_2r_w_s_dff (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_wa    (i_wa),
        .i_wd    (i_wd),
        .i_ra1   (i_ra1),
        .i_ra2   (i_ra2),
        .o_rd1   (w_rd1),
        .o_rd2   (w_rd2)
    );

    assign o_rd1 = (i_ra1 == 5'd0) ? '0 : w_rd1;
    assign o_rd2 = (i_ra2 == 5'd0) ? '0 : w_rd2;
endmodule

// File: rtl/top.sv
// Pin-level wrapper of the single-cycle RV32I core.
// Ports: clk, rst(n), IDT/IAD fetch, DAD/MREQ/WRITE/SIZE/DDT data, IRQ pins.
module top
    import top_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ACKI_n,
    input  logic        ACKD_n,
    input  logic [31:0] IDT,
    input  logic [2:0]  OINT_n,
    output logic [31:0] IAD,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    output logic        IACK_n,
    inout  wire  [31:0] DDT
);
    top_if bus ();

    logic w_unused;

    top_datapath datapath (
        .i_clk   (clk),
        .i_rst_n (rst),
        .bus     (bus.master)
    );

    assign bus.idt   = IDT;
    assign bus.rdata = DDT;

    assign IAD    = bus.iad;
    assign DAD    = bus.dad;
    assign MREQ   = bus.mreq;
    assign WRITE  = bus.write;
    assign SIZE   = bus.size;
    assign IACK_n = 1'b1;

    assign DDT = (bus.mreq & bus.write) ? bus.wdata : 'z;

    // handshake and interrupt pins have no effect on this core
    assign w_unused = &{1'b0, ACKI_n, ACKD_n, OINT_n};

endmodule

// File: tb/tb_top.sv
// Directed-vector bench for the single-cycle RV32I top.
// Driver pushes expectations; a negedge monitor pops and compares.
module tb_top;
    import top_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] iad;
        logic        mreq;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] dad;
        logic [31:0] ddt;
        bit          cd;
        bit          cw;
        int          ridx;
        logic [31:0] rval;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        tb_en;
    logic        IACK_n;
    logic        ACKI_n;
    logic        ACKD_n;
    logic [2:0]  OINT_n;
    wire  [31:0] DDT;

    int   n_tests;
    int   n_fail;
    exp_t q[$];

    top_if bus ();

    top dut (
        .clk    (clk),
        .rst    (rst),
        .ACKI_n (ACKI_n),
        .ACKD_n (ACKD_n),
        .IDT    (bus.idt),
        .OINT_n (OINT_n),
        .IAD    (bus.iad),
        .DAD    (bus.dad),
        .MREQ   (bus.mreq),
        .WRITE  (bus.write),
        .SIZE   (bus.size),
        .IACK_n (IACK_n),
        .DDT    (DDT)
    );

    assign DDT       = tb_en ? bus.wdata : 32'bz;
    assign bus.rdata = DDT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_reg(input int i);
        logic [1023:0] m;
        m = dut.datapath.rf.u_DW_ram_2r_w_s_dff.mem;
        return m[i*32 +: 32];
    endfunction

    task automatic chk(input string n, input string f,
                       input logic [31:0] a,
                       input logic [31:0] x);
        n_tests++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s.%s got %h want %h", n, f, a, x);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "IAD", bus.iad, e.iad);
            chk(e.name, "MREQ", {31'b0, bus.mreq}, {31'b0, e.mreq});
            chk(e.name, "WRITE", {31'b0, bus.write}, {31'b0, e.wr});
            chk(e.name, "SIZE", {30'b0, bus.size}, {30'b0, e.sz});
            chk(e.name, "IACK_n", {31'b0, IACK_n}, 32'd1);
            if (e.cd) chk(e.name, "DAD", bus.dad, e.dad);
            if (e.cw) chk(e.name, "DDT", bus.rdata, e.ddt);
            if (e.ridx >= 0)
                chk(e.name, $sformatf("x%0d", e.ridx),
                    get_reg(e.ridx), e.rval);
        end
    end

    task automatic push(input string n, input logic [31:0] iad,
                        input logic mreq, input logic wr,
                        input logic [1:0] sz,
                        input logic [31:0] dad, input bit cd,
                        input logic [31:0] ddt, input bit cw,
                        input int ridx, input logic [31:0] rval);
        exp_t e;
        e.name = n;  e.iad = iad;  e.mreq = mreq; e.wr = wr;
        e.sz = sz;   e.dad = dad;  e.cd = cd;
        e.ddt = ddt; e.cw = cw;    e.ridx = ridx; e.rval = rval;
        q.push_back(e);
    endtask

    task automatic alu(input string n, input logic [31:0] ins,
                       input logic [31:0] iad,
                       input int ridx, input logic [31:0] rval);
        bus.idt = ins;
        tb_en   = 1'b0;
        push(n, iad, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0,
             32'h0, 1'b0, ridx, rval);
        @(posedge clk); #1;
    endtask

    task automatic st(input string n, input logic [31:0] ins,
                      input logic [31:0] iad, input logic [1:0] sz,
                      input logic [31:0] dad, input logic [31:0] ddt,
                      input int ridx, input logic [31:0] rval);
        bus.idt = ins;
        tb_en   = 1'b0;
        push(n, iad, 1'b1, 1'b1, sz, dad, 1'b1,
             ddt, 1'b1, ridx, rval);
        @(posedge clk); #1;
    endtask

    task automatic ld(input string n, input logic [31:0] ins,
                      input logic [31:0] iad, input logic [1:0] sz,
                      input logic [31:0] dad, input logic [31:0] ldv,
                      input int ridx, input logic [31:0] rval);
        bus.idt   = ins;
        bus.wdata = ldv;
        tb_en     = 1'b1;
        push(n, iad, 1'b1, 1'b0, sz, dad, 1'b1,
             32'h0, 1'b0, ridx, rval);
        @(posedge clk); #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        tb_en     = 1'b0;
        ACKI_n    = 1'b0;
        ACKD_n    = 1'b0;
        OINT_n    = 3'b000;
        bus.idt   = 32'h00000013;
        bus.wdata = 32'h0;
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // SW presented during reset must not reach the bus
        alu("rst0", 32'h0022A023, 32'h00, 5, 32'h0);
        alu("rst1", 32'h0022A023, 32'h00, 1, 32'h0);
        rst = 1'b1;

        alu("addi1", 32'h00500093, 32'h00, 0, 32'h0);
        alu("addi2", 32'hFF908113, 32'h04, 1, 32'h5);
        alu("lui5", 32'h080002B7, 32'h08, 2, 32'hFFFFFFFE);
        st("sw", 32'h0022A023, 32'h0C, 2'b00, 32'h08000000,
           32'hFFFFFFFE, 5, 32'h08000000);
        alu("beq", 32'h00000463, 32'h10, -1, 32'h0);
        ld("lb", 32'h00128183, 32'h18, 2'b10, 32'h08000001,
           32'h00000080, -1, 32'h0);
        ld("lbu", 32'h0012C203, 32'h1C, 2'b10, 32'h08000001,
           32'h00000080, 3, 32'hFFFFFF80);
        alu("jal", 32'hFF1FF0EF, 32'h20, 4, 32'h00000080);
        alu("bne", 32'h00001463, 32'h10, 1, 32'h24);
        alu("lui6", 32'hF0000337, 32'h14, -1, 32'h0);
        alu("addi7", 32'h04100393, 32'h18, 6, 32'hF0000000);
        st("sb_out", 32'h00730023, 32'h1C, 2'b10, 32'hF0000000,
           32'h00000041, 7, 32'h41);
        alu("lui8", 32'hFF000437, 32'h20, -1, 32'h0);
        st("sw_exit", 32'h00742023, 32'h24, 2'b00, 32'hFF000000,
           32'h00000041, 8, 32'hFF000000);
        alu("lui9", 32'h800004B7, 32'h28, -1, 32'h0);
        alu("addi10", 32'h02100513, 32'h2C, 9, 32'h80000000);
        alu("sra", 32'h40A4D5B3, 32'h30, 10, 32'd33);
        alu("addi13", 32'hFFF00693, 32'h34, 11, 32'hC0000000);
        alu("addi14", 32'h00100713, 32'h38, 13, 32'hFFFFFFFF);
        alu("sltu", 32'h00D73633, 32'h3C, 14, 32'h1);
        alu("x0wr", 32'h00500013, 32'h40, 12, 32'h1);
        alu("jalr", 32'h040707E7, 32'h44, 0, 32'h0);
        alu("ecall", 32'h00000073, 32'h40, 15, 32'h48);
        alu("addi1b", 32'h00500093, 32'h44, 1, 32'h24);

        // asynchronous reset in the middle of an instruction
        bus.idt = 32'h00900113;
        push("arst", 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0,
             32'h0, 1'b0, 1, 32'h0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        alu("arst_hold", 32'h00900113, 32'h00, 2, 32'h0);
        rst = 1'b1;
        alu("rel", 32'h00900113, 32'h00, -1, 32'h0);
        alu("rel_nop", 32'h00000013, 32'h04, 2, 32'h9);

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
